// File: rtl/set_assoc_icache.sv
// Set-associative instruction cache with single-line refill and round-robin replacement.
// Lookups happen only in IDLE; one outstanding refill at a time.
module set_assoc_icache #(
   parameter int ADDR_WIDTH  = 17,
   parameter int BLOCK_WIDTH = 4,
   parameter int INDEX_WIDTH = 6,
   parameter int WAYS        = 2
) (
   input  logic                              clkIn,
   input  logic                              resetIn,
   input  logic                              flushIn,
   input  logic                              instrInValid,
   input  logic [ADDR_WIDTH-1:0]             instrAddrIn,
   output logic                              busy,
   output logic                              instrOutValid,
   output logic [31:0]                       instrOut,
   output logic                              memReqValid,
   output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memReqAddr,
   input  logic                              memReqReady,
   input  logic                              memDataValid,
   input  logic [(2**BLOCK_WIDTH)*8-1:0]     memDataIn,
   output logic [1:0]                        dbgStateOut
);

   localparam int TAG_W  = ADDR_WIDTH - BLOCK_WIDTH - INDEX_WIDTH;
   localparam int LINE_W = (2**BLOCK_WIDTH) * 8;
   localparam int SETS   = 2**INDEX_WIDTH;
   localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   // Handshake: a refill request transfers on a rising edge where memReqValid
   // and memReqReady are both high; memDataValid is a one-cycle line strobe.
   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    out_valid_q, out_valid_d;
   logic [31:0]             out_data_q, out_data_d;
   logic                    flushed_q, flushed_d;

   logic [WAYS-1:0]         valid_q [SETS];
   logic [PTR_W-1:0]        ptr_q   [SETS];
   logic [TAG_W-1:0]        tag_q   [SETS][WAYS];
   logic [LINE_W-1:0]       data_q  [SETS][WAYS];

   logic [INDEX_WIDTH-1:0]  lk_index, rf_index;
   logic [TAG_W-1:0]        lk_tag, rf_tag;
   logic                    hit;
   logic [LINE_W-1:0]       hit_line;
   logic [PTR_W-1:0]        victim;
   logic                    use_ptr;
   logic                    refill_we;

   function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                             input logic [BLOCK_WIDTH-1:0] off);
      logic [LINE_W-1:0] sh;
      sh = line >> {off & ~BLOCK_WIDTH'(3), 3'b000};
      return sh[31:0];
   endfunction

   assign lk_index = instrAddrIn[BLOCK_WIDTH+INDEX_WIDTH-1:BLOCK_WIDTH];
   assign lk_tag   = instrAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH+INDEX_WIDTH];
   assign rf_index = addr_q[BLOCK_WIDTH+INDEX_WIDTH-1:BLOCK_WIDTH];
   assign rf_tag   = addr_q[ADDR_WIDTH-1:BLOCK_WIDTH+INDEX_WIDTH];

   always_comb begin
      hit      = 1'b0;
      hit_line = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[lk_index][w] && tag_q[lk_index][w] == lk_tag) begin
            hit      = 1'b1;
            hit_line = data_q[lk_index][w];
         end
      end
   end

   // Lowest invalid way wins; the set pointer is only consulted when the set is full.
   always_comb begin
      victim  = ptr_q[rf_index];
      use_ptr = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[rf_index][w]) begin
            victim  = PTR_W'(w);
            use_ptr = 1'b0;
         end
      end
   end

   assign refill_we = (state_q == S_WAIT) && memDataValid && !flushed_q && !flushIn;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      flushed_d   = flushed_q | (flushIn && (state_q == S_REQ || state_q == S_WAIT));
      case (state_q)
         S_IDLE: begin
            if (instrInValid) begin
               addr_d = instrAddrIn;
               if (hit && !flushIn) begin
                  out_valid_d = 1'b1;
                  out_data_d  = pick_word(hit_line, instrAddrIn[BLOCK_WIDTH-1:0]);
               end else begin
                  state_d   = S_REQ;
                  flushed_d = 1'b0;
               end
            end
         end
         S_REQ: begin
            if (memReqReady) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (memDataValid) begin
               state_d     = S_RESP;
               out_valid_d = 1'b1;
               out_data_d  = pick_word(memDataIn, addr_q[BLOCK_WIDTH-1:0]);
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         flushed_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         flushed_q   <= flushed_d;
      end
   end

   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else if (flushIn) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else if (refill_we) begin
         valid_q[rf_index][victim] <= 1'b1;
         if (use_ptr) ptr_q[rf_index] <= (WAYS > 1) ? ptr_q[rf_index] + PTR_W'(1) : '0;
      end
   end

   // Tag and data arrays carry no reset; valid bits guard them.
   always_ff @(posedge clkIn) begin
      if (refill_we) begin
         tag_q[rf_index][victim]  <= rf_tag;
         data_q[rf_index][victim] <= memDataIn;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign memReqValid   = (state_q == S_REQ);
   assign memReqAddr    = addr_q[ADDR_WIDTH-1:BLOCK_WIDTH];
   assign instrOutValid = out_valid_q;
   assign instrOut      = out_data_q;
   assign dbgStateOut   = state_q;

endmodule

// File: doc/set_assoc_icache.md
SET_ASSOC_ICACHE -- requirements
Module: set_assoc_icache

Interface
REQ-001 Parameter ADDR_WIDTH, default 17: byte-address width.
REQ-002 Parameter BLOCK_WIDTH, default 4: log2 line bytes; line = 2**BLOCK_WIDTH bytes, minimum 4 (one word).
REQ-003 Parameter INDEX_WIDTH, default 6: log2 number of sets.
REQ-004 Parameter WAYS, default 2: associativity; legal values 1, 2, 4.
REQ-005 clkIn  input  1  system clock; all state updates on rising edge.
REQ-006 resetIn  input  1  asynchronous, active-low reset.
REQ-007 flushIn  input  1  invalidate all lines.
REQ-008 instrInValid  input  1  fetch request strobe.
REQ-009 instrAddrIn  input  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
REQ-010 busy  output  1  high whenever FSM is not IDLE; requests are not accepted while high.
REQ-011 instrOutValid  output  1  one-cycle pulse, instruction valid.
REQ-012 instrOut  output  32  fetched instruction.
REQ-013 memReqValid  output  1  line refill request.
REQ-014 memReqAddr  output  ADDR_WIDTH-BLOCK_WIDTH  line address of refill.
REQ-015 memReqReady  input  1  memory accepts request when high together with memReqValid.
REQ-016 memDataValid  input  1  refill line data valid, one-cycle pulse.
REQ-017 memDataIn  input  (2**BLOCK_WIDTH)*8  refill line, byte 0 in bits [7:0].

Function
REQ-018 Address split: offset = addr[BLOCK_WIDTH-1:0]; index = addr[BLOCK_WIDTH+INDEX_WIDTH-1:BLOCK_WIDTH]; tag = addr[ADDR_WIDTH-1:BLOCK_WIDTH+INDEX_WIDTH]; word select = addr[BLOCK_WIDTH-1:2].
REQ-019 Storage per set per way: valid bit, tag, line data; per set: round-robin victim pointer of log2(WAYS) bits (absent when WAYS=1).
REQ-020 FSM states: IDLE, REQ, WAIT, RESP.
REQ-021 IDLE: request accepted when instrInValid=1; address latched; tags of all ways compared in the same cycle.
REQ-022 Hit (any valid way with matching tag): instrOutValid=1 with selected word on the next cycle; FSM stays IDLE; back-to-back hits sustain one instruction per cycle.
REQ-023 Miss: FSM -> REQ next cycle; memReqValid=1, memReqAddr = latched {tag,index}, both held stable until memReqReady=1.
REQ-024 REQ with memReqReady=1: memReqValid drops next cycle; FSM -> WAIT.
REQ-025 WAIT with memDataValid=1: line, tag, valid written into victim way; FSM -> RESP.
REQ-026 RESP: instrOutValid=1, instrOut = requested word taken from memDataIn as captured; FSM -> IDLE next cycle. Miss latency from request to instrOutValid = 3 cycles plus memory delay.
REQ-027 Victim: lowest-numbered invalid way if any; otherwise way selected by set pointer, pointer then increments modulo WAYS. Hits do not modify pointers.
REQ-028 memDataValid outside WAIT is ignored; memReqReady outside REQ is ignored.
REQ-029 flushIn=1: all valid bits cleared on that edge; pointers cleared. Flush during REQ/WAIT: refill continues, response is delivered, line is NOT written. Flush concurrent with an IDLE request: request treated as a miss.
REQ-030 Refill written in the same cycle as an IDLE lookup cannot occur (lookups only in IDLE); no bypass needed.
REQ-031 instrOutValid is low in all cycles other than those in REQ-022/REQ-026; instrOut holds last value when instrOutValid=0.

Reset
REQ-032 resetIn=0 asynchronously forces: FSM IDLE, all valid bits 0, all pointers 0, busy=0, instrOutValid=0, memReqValid=0, instrOut=0, memReqAddr=0.
REQ-033 Reset mid-refill abandons the transaction; a later memDataValid is ignored.
REQ-034 Tag and data arrays need not be reset.

Verification
REQ-035 Cold fetch 0x00104, memReqReady=1 immediately, data 3 cycles later with word1=0x00A00093 -> memReqAddr=0x0010, instrOutValid with 0x00A00093, busy low after RESP.
REQ-036 Refetch 0x00100, 0x00104, 0x00108 on consecutive cycles after that refill -> three hits, instrOutValid high three consecutive cycles, no memReqValid.
REQ-037 WAYS=2: fill 0x00000, 0x00400, 0x00800 (same index 0) -> third refill evicts way 0; fetch 0x00000 misses, 0x00400 hits.
REQ-038 memReqReady held low 5 cycles -> memReqValid and memReqAddr stable all 5 cycles; busy=1; instrInValid during this ignored.
REQ-039 flushIn pulsed in WAIT, then fetch same address -> first response delivered, second fetch misses again.
REQ-040 resetIn low during WAIT, then memDataValid pulse -> no instrOutValid, no line written, busy=0.
